// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: register scoreboard, RAW/memory stalls,
// branch flush sequencing and halt handling for a 5-stage in-order core.
module pipeline_ctrl #(
    parameter int REG_ADDR_LEN = 5,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic                    id_rs1_en,
    input  logic                    id_rs2_en,
    input  logic [REG_ADDR_LEN-1:0] id_rd,
    input  logic                    id_rd_en,
    input  logic                    ex_branch_taken,
    input  logic                    dmem_busy,
    input  logic [REG_ADDR_LEN-1:0] wb_rd,
    input  logic                    wb_rd_en,
    input  logic                    wb_halt,
    output logic                    pc_hold,
    output logic                    if_id_hold,
    output logic                    id_ex_hold,
    output logic                    ex_mem_hold,
    output logic                    id_ex_bubble,
    output logic                    mem_wb_bubble,
    output logic                    if_id_flush,
    output logic                    id_ex_flush,
    output logic                    halt,
    output logic [2:0]              state,
    output logic [15:0]             stall_count
);

    localparam int NREG = 1 << REG_ADDR_LEN;
    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    typedef enum logic [2:0] {
        S_RUN       = 3'd0,
        S_STALL_RAW = 3'd1,
        S_STALL_MEM = 3'd2,
        S_FLUSH     = 3'd3,
        S_HALTED    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        halt_q, halt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  sb_q [NREG];
    logic [1:0]  sb_d [NREG];

    logic raw_hazard;
    logic issue;
    logic retire;
    logic same_reg;

    // Entry 0 of the scoreboard is held at zero, so x0 never looks pending.
    assign raw_hazard = id_valid &
                        ((id_rs1_en & (sb_q[id_rs1] != 2'd0)) |
                         (id_rs2_en & (sb_q[id_rs2] != 2'd0)));

    assign issue = id_valid & id_rd_en &
                   ~(if_id_hold | id_ex_hold | id_ex_bubble |
                     if_id_flush | id_ex_flush);

    assign retire   = wb_rd_en & (wb_rd != '0);
    assign same_reg = issue & retire & (wb_rd == id_rd);

    always_comb begin
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_hold   = 1'b0;
        id_ex_bubble  = 1'b0;
        mem_wb_bubble = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;

        if (state_q == S_HALTED) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = S_HALTED;
        end else if (dmem_busy) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = S_STALL_MEM;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_cnt_d = FLUSH_INIT;
            state_d     = S_FLUSH;
        end else if (flush_cnt_q != 2'd0) begin
            // Also resumes a flush that a memory stall interrupted.
            if_id_flush = 1'b1;
            flush_cnt_d = flush_cnt_q - 2'd1;
            state_d     = (flush_cnt_q == 2'd1) ? S_RUN : S_FLUSH;
        end else if (raw_hazard) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = S_STALL_RAW;
        end else begin
            state_d = S_RUN;
        end

        if (wb_halt && state_q != S_HALTED) begin
            state_d = S_HALTED;
        end
    end

    always_comb begin
        halt_d      = (state_d == S_HALTED);
        stall_cnt_d = stall_cnt_q;
        if ((state_d == S_STALL_RAW || state_d == S_STALL_MEM) &&
            stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_d[i] = sb_q[i];
        end
        if (issue && !same_reg && id_rd != '0) begin
            sb_d[id_rd] = sb_q[id_rd] + 2'd1;
        end
        if (retire && !same_reg && sb_q[wb_rd] != 2'd0) begin
            sb_d[wb_rd] = sb_q[wb_rd] - 2'd1;
        end
        sb_d[0] = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            flush_cnt_q <= 2'd0;
            halt_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
            for (int i = 0; i < NREG; i++) begin
                sb_q[i] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < NREG; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // Pipeline depth bounds in-flight writers per register to three.
    a_sb_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(issue && !same_reg && id_rd != '0 && sb_q[id_rd] == 2'd3));

    assign state       = state_q;
    assign halt        = halt_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (FLUSH_CYCLES = 2).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_rs1_en, id_rs2_en, id_rd_en;
    logic        ex_branch_taken, dmem_busy, wb_rd_en, wb_halt;
    logic        pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic        id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush;
    logic        halt;
    logic [2:0]  state;
    logic [15:0] stall_count;

    int npass = 0;
    int ntot  = 0;

    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_RAW  = 8'b1100_1000;
    localparam logic [7:0] O_MEM  = 8'b1111_0100;
    localparam logic [7:0] O_BR   = 8'b0000_0011;
    localparam logic [7:0] O_FL   = 8'b0000_0010;

    localparam logic [2:0] RUN = 3'd0, SRAW = 3'd1, SMEM = 3'd2;
    localparam logic [2:0] FLU = 3'd3, HLT = 3'd4;

    pipeline_ctrl #(.REG_ADDR_LEN(5), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_rd_en(id_rd_en),
        .ex_branch_taken(ex_branch_taken), .dmem_busy(dmem_busy),
        .wb_rd(wb_rd), .wb_rd_en(wb_rd_en), .wb_halt(wb_halt),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold),
        .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halt(halt), .state(state), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_en = 0; id_rs2_en = 0; id_rd_en = 0;
        ex_branch_taken = 0; dmem_busy = 0;
        wb_rd = 0; wb_rd_en = 0; wb_halt = 0;
    endtask

    task automatic id_in(input logic [4:0] r1, input logic e1,
                         input logic [4:0] r2, input logic e2,
                         input logic [4:0] rd, input logic ed);
        id_valid = 1;
        id_rs1 = r1; id_rs1_en = e1;
        id_rs2 = r2; id_rs2_en = e2;
        id_rd = rd;  id_rd_en = ed;
    endtask

    task automatic wb_in(input logic [4:0] rd);
        wb_rd = rd;
        wb_rd_en = 1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_cyc(input string tag, input logic [7:0] eo,
                           input logic [2:0] es, input logic [15:0] esc);
        logic [7:0] outs;
        #4;
        outs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                id_ex_bubble, mem_wb_bubble, if_id_flush, id_ex_flush};
        chk({tag, ".ctl"}, {8'h00, outs}, {8'h00, eo});
        chk({tag, ".state"}, {13'd0, state}, {13'd0, es});
        chk({tag, ".halt"}, {15'd0, halt}, {15'd0, (es == HLT)});
        chk({tag, ".stall"}, stall_count, esc);
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        idle(); chk_cyc("reset", O_NONE, RUN, 16'd0);

        idle(); id_in(0, 0, 0, 0, 5, 1);
        chk_cyc("raw_issue5", O_NONE, RUN, 16'd0);
        idle(); id_in(5, 1, 0, 0, 6, 1);
        chk_cyc("raw_stall1", O_RAW, RUN, 16'd0);
        idle(); id_in(5, 1, 0, 0, 6, 1);
        chk_cyc("raw_stall2", O_RAW, SRAW, 16'd1);
        idle(); id_in(5, 1, 0, 0, 6, 1); wb_in(5);
        chk_cyc("raw_wb_same", O_RAW, SRAW, 16'd2);
        idle(); id_in(5, 1, 0, 0, 6, 1);
        chk_cyc("raw_clear", O_NONE, SRAW, 16'd3);
        idle(); wb_in(6);
        chk_cyc("raw_run", O_NONE, RUN, 16'd3);

        idle(); id_in(0, 0, 0, 0, 7, 1);
        chk_cyc("ir_issue7", O_NONE, RUN, 16'd3);
        idle(); id_in(0, 0, 0, 0, 7, 1); wb_in(7);
        chk_cyc("ir_both7", O_NONE, RUN, 16'd3);
        idle(); id_in(7, 1, 0, 0, 0, 0);
        chk_cyc("ir_dep7", O_RAW, RUN, 16'd3);
        idle(); id_in(7, 1, 0, 0, 0, 0); wb_in(7);
        chk_cyc("ir_wb7", O_RAW, SRAW, 16'd4);
        idle(); id_in(7, 1, 0, 0, 0, 0);
        chk_cyc("ir_clear7", O_NONE, SRAW, 16'd5);
        idle(); chk_cyc("ir_run", O_NONE, RUN, 16'd5);

        idle(); ex_branch_taken = 1; id_in(0, 0, 0, 0, 9, 1);
        chk_cyc("br_take", O_BR, RUN, 16'd5);
        idle(); id_in(0, 0, 0, 0, 10, 1);
        chk_cyc("br_fl1", O_FL, FLU, 16'd5);
        idle(); chk_cyc("br_fl2", O_FL, FLU, 16'd5);
        idle(); id_in(9, 1, 10, 1, 0, 0);
        chk_cyc("br_noinc", O_NONE, RUN, 16'd5);

        idle(); id_in(0, 0, 0, 0, 12, 1);
        chk_cyc("mb_issue12", O_NONE, RUN, 16'd5);
        idle(); dmem_busy = 1; ex_branch_taken = 1; id_in(12, 1, 0, 0, 0, 0);
        chk_cyc("mb_busy1", O_MEM, RUN, 16'd5);
        idle(); dmem_busy = 1; ex_branch_taken = 1; id_in(12, 1, 0, 0, 0, 0);
        chk_cyc("mb_busy2", O_MEM, SMEM, 16'd6);
        idle(); dmem_busy = 1; ex_branch_taken = 1; id_in(12, 1, 0, 0, 0, 0);
        chk_cyc("mb_busy3", O_MEM, SMEM, 16'd7);
        idle(); ex_branch_taken = 1; id_in(12, 1, 0, 0, 0, 0);
        chk_cyc("mb_branch", O_BR, SMEM, 16'd8);
        idle(); wb_in(12);
        chk_cyc("mb_fl1", O_FL, FLU, 16'd8);
        idle(); chk_cyc("mb_fl2", O_FL, FLU, 16'd8);
        idle(); chk_cyc("mb_run", O_NONE, RUN, 16'd8);

        idle(); ex_branch_taken = 1;
        chk_cyc("fp_take", O_BR, RUN, 16'd8);
        idle(); dmem_busy = 1;
        chk_cyc("fp_busy", O_MEM, FLU, 16'd8);
        idle(); chk_cyc("fp_resume1", O_FL, SMEM, 16'd9);
        idle(); chk_cyc("fp_resume2", O_FL, FLU, 16'd9);
        idle(); chk_cyc("fp_run", O_NONE, RUN, 16'd9);

        idle(); id_in(0, 0, 0, 0, 3, 1);
        chk_cyc("rs_issue3", O_NONE, RUN, 16'd9);
        idle(); id_in(3, 1, 0, 0, 0, 0);
        chk_cyc("rs_stall1", O_RAW, RUN, 16'd9);
        idle(); id_in(3, 1, 0, 0, 0, 0);
        chk_cyc("rs_stall2", O_RAW, SRAW, 16'd10);
        idle(); id_in(3, 1, 0, 0, 0, 0); rst = 1;
        tick();
        rst = 0;
        idle(); id_in(3, 1, 12, 1, 0, 0);
        chk_cyc("rs_after", O_NONE, RUN, 16'd0);

        idle(); wb_halt = 1;
        chk_cyc("h_pulse", O_NONE, RUN, 16'd0);
        idle(); ex_branch_taken = 1; id_in(3, 1, 0, 0, 4, 1);
        chk_cyc("h_halted1", O_MEM, HLT, 16'd0);
        idle(); dmem_busy = 1;
        chk_cyc("h_halted2", O_MEM, HLT, 16'd0);
        idle(); chk_cyc("h_halted3", O_MEM, HLT, 16'd0);
        idle(); rst = 1;
        tick();
        rst = 0;
        idle(); chk_cyc("h_reset", O_NONE, RUN, 16'd0);
        idle(); id_in(4, 1, 0, 0, 0, 0);
        chk_cyc("h_nopend4", O_NONE, RUN, 16'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_LEN, default 5, register-address width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, extra cycles (1..3) IF_ID stays flushed after a taken branch.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state on rising edge; rst  in  1  synchronous active-high reset.
REQ-004 Inputs, ID stage: id_valid 1 (instruction present); id_rs1, id_rs2 REG_ADDR_LEN (source regs); id_rs1_en, id_rs2_en 1 (source used); id_rd REG_ADDR_LEN (dest reg); id_rd_en 1 (writes reg).
REQ-005 Inputs, other stages: ex_branch_taken 1 (EXE resolved taken branch); dmem_busy 1 (MEM stage access incomplete); wb_rd REG_ADDR_LEN, wb_rd_en 1 (WB register write); wb_halt 1 (WB retiring halt).
REQ-006 Outputs: pc_hold, if_id_hold, id_ex_hold, ex_mem_hold 1 each (freeze stage); id_ex_bubble 1 (load NOP into ID_EXE); mem_wb_bubble 1 (load NOP into MEM_WB); if_id_flush, id_ex_flush 1 each; halt 1; state 3 (current FSM state); stall_count 16 (stall cycles).

Function
REQ-007 FSM states: RUN=0, STALL_RAW=1, STALL_MEM=2, FLUSH=3, HALTED=4; state output equals the encoding.
REQ-008 Scoreboard: one 2-bit pending counter per register 1..2^REG_ADDR_LEN-1; register 0 never pending.
REQ-009 Issue = id_valid & id_rd_en & no hold/bubble/flush on ID this cycle; issue increments counter[id_rd] at clock edge.
REQ-010 wb_rd_en with wb_rd!=0 decrements counter[wb_rd]; issue and retire to same reg in one cycle leave counter unchanged; decrement at 0 stays 0; increment at 3 is not possible (pipeline depth) and SHALL assert in simulation.
REQ-011 RAW hazard (combinational) = id_valid & ((id_rs1_en & counter[id_rs1]!=0) | (id_rs2_en & counter[id_rs2]!=0)); a write retiring this cycle does not clear hazard this cycle.
REQ-012 Priority each cycle: HALTED > dmem_busy > ex_branch_taken > RAW > RUN.
REQ-013 dmem_busy (not HALTED): pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, mem_wb_bubble = 1 same cycle; next state STALL_MEM; no issue, no flush action.
REQ-014 ex_branch_taken (no dmem_busy): if_id_flush = id_ex_flush = 1 same cycle; no issue; next state FLUSH with counter loaded FLUSH_CYCLES.
REQ-015 FLUSH: if_id_flush = 1, ID issue suppressed, counter decrements each cycle; exit to RUN when it reaches 0; a new ex_branch_taken in FLUSH reloads counter; dmem_busy preempts to STALL_MEM, flush counter retained and resumed afterwards.
REQ-016 RAW (no higher event): pc_hold = if_id_hold = id_ex_bubble = 1 same cycle; next state STALL_RAW; returns to RUN in the first cycle the hazard clears.
REQ-017 All outputs combinational from current inputs, scoreboard and state except halt, state, stall_count (registered).
REQ-018 wb_halt: next state HALTED; halt = 1 from the following cycle; HALTED holds all of pc_hold..ex_mem_hold = 1, mem_wb_bubble = 1, sticky until rst.
REQ-019 stall_count increments once per cycle spent with next state STALL_RAW or STALL_MEM; saturates at 16'hFFFF.

Reset
REQ-020 rst (sampled on clk) SHALL, regardless of state or mid-stall: state=RUN, all scoreboard counters=0, flush counter=0, halt=0, stall_count=0; combinational outputs then reflect RUN with empty scoreboard (all 0 when inputs idle).

Verification
REQ-021 RAW: issue id_rd=5 cycle 0; cycle 1 id_rs1=5 en -> pc_hold/if_id_hold/id_ex_bubble=1, state STALL_RAW until cycle after wb_rd=5 wb_rd_en; stall_count = stall cycles.
REQ-022 Same-cycle issue+retire rd=7 with counter[7]=1 -> counter stays 1; dependent rs1=7 still stalls.
REQ-023 ex_branch_taken with FLUSH_CYCLES=2 -> flush both regs that cycle, if_id_flush 2 more cycles, no scoreboard increment for flushed ID instruction, then RUN.
REQ-024 dmem_busy for 3 cycles concurrent with RAW and branch -> only STALL_MEM outputs, stall_count +3, branch flush performed when busy drops.
REQ-025 wb_halt pulse -> halt=1 next cycle, all holds 1, persists through further inputs; rst -> halt=0, state=0, stall_count=0.
REQ-026 Assert rst during STALL_RAW with pending counters -> next cycle state RUN, no hazard on any source register.
